// File: rtl/window_scan_scheduler.sv
// Window-origin scan sequencer: walks origins row-major and drives the window loader
// start/done/ack handshake, throttled by two buffer credits. Optional: `SCAN_STALL_COUNT_EN.
module window_scan_scheduler #(
  parameter int Y_BITS     = 10,
  parameter int BLOCK_BITS = 6,
  parameter int WIN_BITS   = 6,
  parameter int BLOCK_STEP = 1,
  parameter int Y_STEP     = 1,
  parameter int CNT_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [Y_BITS-1:0]     last_y,
  input  logic [BLOCK_BITS-1:0] last_block,
  input  logic [WIN_BITS-1:0]   win_size,
  input  logic                  core_release,
  input  logic                  wl_ready,
  input  logic                  wl_done,
  output logic                  wl_start,
  output logic [Y_BITS-1:0]     wl_start_y,
  output logic [BLOCK_BITS-1:0] wl_start_block,
  output logic [WIN_BITS-1:0]   wl_win_size,
  output logic                  wl_dbl_buf,
  output logic                  wl_ack,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CNT_BITS-1:0]   jobs_issued
`ifdef SCAN_STALL_COUNT_EN
  ,
  output logic [CNT_BITS-1:0]   stall_cycles
`endif
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, ADVANCE, FINISH} state_t;

  localparam logic [BLOCK_BITS:0] BLOCK_INC = (BLOCK_BITS+1)'(BLOCK_STEP);
  localparam logic [Y_BITS:0]     Y_INC     = (Y_BITS+1)'(Y_STEP);

  state_t                state, state_next;
  logic [1:0]            credits;
  logic [Y_BITS-1:0]     y, last_y_r;
  logic [BLOCK_BITS-1:0] block, last_block_r;
  logic [WIN_BITS-1:0]   win_r;
  logic                  buf_sel;
  logic                  accept, issue, ack, finish;
  logic [BLOCK_BITS:0]   block_sum;
  logic [Y_BITS:0]       y_sum;
  logic                  block_more, y_more;

  // One spare bit on the sums so a max-code last_block/last_y ends the scan instead of wrapping
  assign block_sum  = {1'b0, block} + BLOCK_INC;
  assign y_sum      = {1'b0, y} + Y_INC;
  assign block_more = (block_sum <= {1'b0, last_block_r});
  assign y_more     = (y_sum <= {1'b0, last_y_r});

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    ack        = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (wl_ready && (credits != 2'd0)) begin
          issue      = 1'b1;
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (wl_done) begin
          ack        = 1'b1;
          state_next = ADVANCE;
        end
      end
      ADVANCE: begin
        if (block_more || y_more) begin
          state_next = ISSUE;
        end else begin
          finish     = 1'b1;
          state_next = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wl_start       <= 1'b0;
      wl_ack         <= 1'b0;
      frame_done     <= 1'b0;
      busy           <= 1'b0;
      wl_start_y     <= '0;
      wl_start_block <= '0;
      wl_win_size    <= '0;
      wl_dbl_buf     <= 1'b0;
      jobs_issued    <= '0;
      credits        <= 2'd2;
      y              <= '0;
      block          <= '0;
      last_y_r       <= '0;
      last_block_r   <= '0;
      win_r          <= '0;
      buf_sel        <= 1'b0;
    end else begin
      wl_start   <= issue;
      wl_ack     <= ack;
      frame_done <= finish;
      if (accept) begin
        last_y_r     <= last_y;
        last_block_r <= last_block;
        win_r        <= win_size;
        y            <= '0;
        block        <= '0;
        jobs_issued  <= '0;
        busy         <= 1'b1;
      end
      if (state == FINISH) busy <= 1'b0;
      // Job fields are captured at issue so they hold steady until the ack
      if (issue) begin
        wl_start_y     <= y;
        wl_start_block <= block;
        wl_win_size    <= win_r;
        wl_dbl_buf     <= buf_sel;
        jobs_issued    <= jobs_issued + 1'b1;
      end
      if (state == ADVANCE) begin
        buf_sel <= ~buf_sel;
        if (block_more) begin
          block <= block_sum[BLOCK_BITS-1:0];
        end else if (y_more) begin
          block <= '0;
          y     <= y_sum[Y_BITS-1:0];
        end
      end
      // A release landing with an issue cancels out; releases beyond two credits are dropped
      if (issue && !core_release)
        credits <= credits - 2'd1;
      else if (!issue && core_release && (credits != 2'd2))
        credits <= credits + 2'd1;
    end
  end

`ifdef SCAN_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset || accept)
      stall_cycles <= '0;
    else if ((state == ISSUE) && (credits == 2'd0) && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 1'b1;
  end
`endif

endmodule
